// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory; byte-strobed stores become read-modify-write word writes.
// Define DMEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (port 0 first).
module data_mem_arbiter #(
    parameter int  WORD_COUNT     = 128,
    parameter int  WORD_BITS      = 32,
    localparam int BYTES_PER_WORD = WORD_BITS / 8,
    localparam int ADDR_BITS      = $clog2(WORD_COUNT * BYTES_PER_WORD)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [1:0]                          req_valid,
    output logic [1:0]                          req_ready,
    input  logic [1:0][ADDR_BITS-1:0]           req_addr,
    input  logic [1:0]                          req_we,
    input  logic [1:0][WORD_BITS-1:0]           req_wdata,
    input  logic [1:0][BYTES_PER_WORD-1:0]      req_wstrb,
    output logic [1:0]                          rsp_valid,
    input  logic [1:0]                          rsp_ready,
    output logic [WORD_BITS-1:0]                rsp_rdata,
    output logic [ADDR_BITS-1:0]                mem_address,
    input  logic [WORD_BITS-1:0]                mem_rd_data,
    output logic [WORD_BITS-1:0]                mem_wr_data,
    output logic                                mem_wr_en
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                    state;
    logic [ADDR_BITS-1:0]      addr_q;
    logic                      we_q;
    logic [WORD_BITS-1:0]      wdata_q;
    logic [BYTES_PER_WORD-1:0] wstrb_q;
    logic                      owner_q;
    logic [1:0]                grant;
    logic                      win_port;
    logic [WORD_BITS-1:0]      mask;
    logic [WORD_BITS-1:0]      merged;
    logic                      exec_active;

`ifdef DMEM_ARB_RR_EN
    logic                      last_grant;
`endif

    // Winner is purely combinational from req_valid so a request can be accepted the cycle it appears.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            grant = last_grant ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end
    end

    assign win_port  = grant[1];
    assign req_ready = (state == IDLE && !reset) ? grant : 2'b00;

    always_comb begin
        mask = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            mask[8*i +: 8] = {8{wstrb_q[i]}};
        end
    end

    assign merged      = (mem_rd_data & ~mask) | (wdata_q & mask);
    // Gating with reset keeps a reset that lands in EXEC from committing the write.
    assign exec_active = (state == EXEC) && !reset;
    assign mem_address = exec_active ? (addr_q & ~ADDR_BITS'(BYTES_PER_WORD - 1)) : '0;
    assign mem_wr_data = (exec_active && we_q) ? merged : '0;
    assign mem_wr_en   = exec_active && we_q && (wstrb_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            owner_q   <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
`ifdef DMEM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        addr_q  <= req_addr[win_port];
                        we_q    <= req_we[win_port];
                        wdata_q <= req_wdata[win_port];
                        wstrb_q <= req_wstrb[win_port];
                        owner_q <= win_port;
`ifdef DMEM_ARB_RR_EN
                        last_grant <= win_port;
`endif
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_rdata <= we_q ? merged : mem_rd_data;
                    rsp_valid <= owner_q ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: bench-owned memory, transaction-level reference model, directed and random traffic.
module tb_data_mem_arbiter;

    localparam int WB = 32;
    localparam int AB = 9;
    localparam int NW = 128;

    typedef struct packed {
        logic          we;
        logic [AB-1:0] addr;
        logic [WB-1:0] wdata;
        logic [3:0]    wstrb;
    } req_t;

    logic                clk;
    logic                reset;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0][AB-1:0]  req_addr;
    logic [1:0]          req_we;
    logic [1:0][WB-1:0]  req_wdata;
    logic [1:0][3:0]     req_wstrb;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [WB-1:0]       rsp_rdata;
    logic [AB-1:0]       mem_address;
    logic [WB-1:0]       mem_rd_data;
    logic [WB-1:0]       mem_wr_data;
    logic                mem_wr_en;

    data_mem_arbiter #(.WORD_COUNT(NW), .WORD_BITS(WB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_rd_data(mem_rd_data),
        .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WB-1:0] mem [NW];
    logic          pre_en;
    logic [6:0]    pre_idx;
    logic [WB-1:0] pre_val;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_wr_en) mem[mem_address[AB-1:2]] <= mem_wr_data;
    end
    assign mem_rd_data = mem[mem_address[AB-1:2]];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_count = 0;

    logic [WB-1:0] ref_mem [NW];
    bit            busy;
    int            age;
    int            lastp;
    int            cur_port;
    req_t          cur;
    logic [WB-1:0] exp_data;
    logic [WB-1:0] exp_rdata;
    int            grant_log[$];
    int            acc_cyc;
    int            last_latency;
    bit            rv_seen;
    logic [1:0]    acc_seen;
    bit            chk_en;
    int            rsp_mode;
    req_t          q0[$];
    req_t          q1[$];
    int            exp_grants [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [AB-1:0] addr,
                                 input logic [WB-1:0] wdata, input logic [3:0] wstrb);
        req_t r;
        r.we = we;
        r.addr = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        if (port == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    task automatic preloadWord(input int idx, input logic [WB-1:0] val);
        @(posedge clk);
        #1;
        pre_en = 1'b1;
        pre_idx = 7'(idx);
        pre_val = val;
        ref_mem[idx] = val;
    endtask

    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: wait bound expired, got timeout expected completion", name);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        bit idle;
        n = 0;
        idle = 0;
        while (!idle && n < budget) begin
            @(posedge clk);
            #2;
            n++;
            idle = (q0.size() == 0) && (q1.size() == 0) && (req_valid == 2'b00) && !busy;
        end
        if (!idle) timeoutFail("wait_idle");
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [1:0] modelWinner(input logic [1:0] v, input int lp);
        if (v == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            return (lp == 0) ? 2'b10 : 2'b01;
`else
            return 2'b01;
`endif
        end
        return v;
    endfunction

    function automatic logic [WB-1:0] mergeBytes(input logic [WB-1:0] old, input logic [WB-1:0] nw,
                                                 input logic [3:0] strb);
        logic [WB-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Reference model: one transaction at a time, counted in cycles since its acceptance.
    always @(negedge clk) begin
        logic [1:0] exp_ready;
        logic [1:0] exp_rv;
        logic       exp_we;
        logic       in_exec;
        cyc++;
        if (chk_en) begin
            in_exec   = busy && age == 1 && !reset;
            exp_ready = (!busy && !reset) ? modelWinner(req_valid, lastp) : 2'b00;
            exp_rv    = (busy && age >= 2) ? ((cur_port == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_we    = in_exec && cur.we && (cur.wstrb != 4'b0);
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
            checkOutput("mem_wr_en", 32'(mem_wr_en), 32'(exp_we));
            if (in_exec) checkOutput("mem_word", 32'(mem_address[AB-1:2]), 32'(cur.addr[AB-1:2]));
            else checkOutput("mem_address_idle", 32'(mem_address), 32'h0);
            if (exp_we) checkOutput("mem_wr_data", mem_wr_data, exp_data);
            else if (!in_exec) checkOutput("mem_wr_data_idle", mem_wr_data, 32'h0);
            if (mem_wr_en) wr_count++;
            if (rsp_valid != 2'b00 && busy && !rv_seen) begin
                rv_seen = 1'b1;
                last_latency = cyc - acc_cyc;
            end

            if (reset) begin
                busy = 1'b0;
                exp_rdata = '0;
                lastp = 1;
            end else if (!busy) begin
                if ((req_valid & exp_ready) != 2'b00) begin
                    cur_port = exp_ready[1] ? 1 : 0;
                    cur.we = req_we[cur_port];
                    cur.addr = req_addr[cur_port];
                    cur.wdata = req_wdata[cur_port];
                    cur.wstrb = req_wstrb[cur_port];
                    busy = 1'b1;
                    age = 1;
                    lastp = cur_port;
                    grant_log.push_back(cur_port);
                    acc_cyc = cyc;
                    rv_seen = 1'b0;
                    exp_data = cur.we ? mergeBytes(ref_mem[cur.addr[AB-1:2]], cur.wdata, cur.wstrb)
                                      : ref_mem[cur.addr[AB-1:2]];
                end
            end else if (age == 1) begin
                if (cur.we && cur.wstrb != 4'b0) ref_mem[cur.addr[AB-1:2]] = exp_data;
                exp_rdata = exp_data;
                age = 2;
            end else if (rsp_ready[cur_port]) begin
                busy = 1'b0;
            end
        end
        acc_seen = req_valid & req_ready;
    end

    // Requester side: hold each request until its handshake, then present the next queued one.
    initial begin
        req_valid = 2'b00;
        req_we = 2'b00;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (acc_seen[p] || !req_valid[p]) begin
                    req_t nxt;
                    bit have;
                    have = 1'b0;
                    nxt = '0;
                    if (p == 0 && q0.size() > 0) begin nxt = q0.pop_front(); have = 1'b1; end
                    if (p == 1 && q1.size() > 0) begin nxt = q1.pop_front(); have = 1'b1; end
                    req_valid[p] = have;
                    if (have) begin
                        req_we[p] = nxt.we;
                        req_addr[p] = nxt.addr;
                        req_wdata[p] = nxt.wdata;
                        req_wstrb[p] = nxt.wstrb;
                    end
                end
            end
            case (rsp_mode)
                0: rsp_ready = 2'b11;
                1: rsp_ready = 2'($urandom_range(0, 3));
                default: rsp_ready = 2'b00;
            endcase
        end
    end

    initial begin
        int w0;
        int n;
        reset = 1'b1;
        chk_en = 1'b0;
        pre_en = 1'b0;
        pre_idx = '0;
        pre_val = '0;
        rsp_mode = 0;
        busy = 1'b0;
        age = 0;
        lastp = 1;
        cur_port = 0;
        cur = '0;
        exp_data = '0;
        exp_rdata = '0;
        acc_seen = 2'b00;
        acc_cyc = 0;
        last_latency = -1;
        rv_seen = 1'b0;
`ifdef DMEM_ARB_RR_EN
        exp_grants = '{0, 1, 0, 1, 0, 1};
`else
        exp_grants = '{0, 0, 0, 1, 1, 1};
`endif
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_mem_wr_en", 32'(mem_wr_en), 32'h0);
        checkOutput("reset_mem_address", 32'(mem_address), 32'h0);

        for (int i = 0; i < NW; i++) preloadWord(i, $urandom);
        preloadWord(4, 32'hDEADBEEF);
        preloadWord(7, 32'h0BADF00D);
        preloadWord(41, 32'hA5A5A5A5);
        preloadWord(48, 32'h12345678);
        @(posedge clk);
        #1;
        pre_en = 1'b0;
        reset = 1'b0;

        $display("[TB] directed: load, byte store, empty-strobe store");
        applyStimulus(0, 1'b0, 9'h010, 32'h0, 4'h0);
        waitIdle(50);
        checkOutput("t_load_rdata", rsp_rdata, 32'hDEADBEEF);
        checkOutput("t_load_latency", 32'(last_latency), 32'd2);
        checkOutput("t_load_grant", 32'(grant_log[$]), 32'd0);

        applyStimulus(1, 1'b1, 9'h0A4, 32'h11223344, 4'b0010);
        waitIdle(50);
        checkOutput("t_store_mem", mem[41], 32'hA5A533A5);
        checkOutput("t_store_rdata", rsp_rdata, 32'hA5A533A5);

        w0 = wr_count;
        applyStimulus(0, 1'b1, 9'h0A6, 32'hFFFFFFFF, 4'b0000);
        waitIdle(50);
        checkOutput("t_nostrb_writes", 32'(wr_count - w0), 32'd0);
        checkOutput("t_nostrb_mem", mem[41], 32'hA5A533A5);
        checkOutput("t_nostrb_rdata", rsp_rdata, 32'hA5A533A5);

        $display("[TB] directed: contention");
        pulseReset();
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b0, 9'(4 * i), 32'h0, 4'h0);
            applyStimulus(1, 1'b0, 9'(4 * i + 12), 32'h0, 4'h0);
        end
        waitIdle(200);
        checkOutput("t_grant_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            checkOutput("t_grant_order", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFFFFFF,
                        32'(exp_grants[i]));

        $display("[TB] directed: response backpressure");
        rsp_mode = 2;
        applyStimulus(1, 1'b0, 9'h01C, 32'h0, 4'h0);
        n = 0;
        while (rsp_valid == 2'b00 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (rsp_valid == 2'b00) timeoutFail("wait_rsp_valid");
        applyStimulus(0, 1'b0, 9'h000, 32'h0, 4'h0);
        repeat (5) begin
            @(posedge clk);
            #2;
            checkOutput("t_hold_rsp_valid", 32'(rsp_valid), 32'h2);
            checkOutput("t_hold_rsp_rdata", rsp_rdata, 32'h0BADF00D);
            checkOutput("t_hold_req_ready", 32'(req_ready), 32'h0);
        end
        rsp_mode = 0;
        waitIdle(50);

        $display("[TB] directed: reset during store execution");
        applyStimulus(0, 1'b1, 9'h0C0, 32'hFFFFFFFF, 4'b1111);
        n = 0;
        while (!(busy && age == 1) && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!(busy && age == 1)) timeoutFail("wait_exec");
        reset = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("t_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("t_rst_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("t_rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
        checkOutput("t_rst_mem_address", 32'(mem_address), 32'h0);
        checkOutput("t_rst_req_ready", 32'(req_ready), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("t_rst_mem_kept", mem[48], 32'h12345678);
        applyStimulus(1, 1'b0, 9'h0C1, 32'h0, 4'h0);
        waitIdle(50);
        checkOutput("t_rst_reload", rsp_rdata, 32'h12345678);

        $display("[TB] random traffic");
        rsp_mode = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (q0.size() < 2 && $urandom_range(0, 1) == 1)
                applyStimulus(0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 31)), $urandom,
                              4'($urandom_range(0, 15)));
            if (q1.size() < 2 && $urandom_range(0, 1) == 1)
                applyStimulus(1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 31)), $urandom,
                              4'($urandom_range(0, 15)));
        end
        rsp_mode = 0;
        waitIdle(5000);
        for (int i = 0; i < NW; i++) checkOutput("mem_final", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
